// File: rtl/echo_delay_line.sv
// Echo delay line: offset-binary in, delayed scaled echo subtracted, offset-binary out.
// Optional output/RAM clamping is built when ECHO_SAT_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | zeroing delay RAM after reset, busy high, strobes dropped
// S_IDLE  | waiting for a data_valid rising edge
// S_READ  | RAM read issued at rd_ptr, output settling
// S_CALC  | echo scaled and subtracted, y registered
// S_WRITE | RAM written at wr_ptr, data_out updated, out_valid pulsed
module echo_delay_line #(
  parameter int              DW         = 10,
  parameter int              AW         = 13,
  parameter logic [DW-1:0]   ADC_OFFSET = 10'h181,
  parameter logic [DW-1:0]   DAC_OFFSET = 10'h200,
  parameter int              GAIN_SHIFT = 1,
  parameter int              DELAY_LSB  = 4
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic [DW-1:0]         data_in,
  input  logic                  data_valid,
  input  logic [AW-DELAY_LSB-1:0] delay_sel,
  input  logic                  mode,
  input  logic                  bypass,
  output logic [DW-1:0]         data_out,
  output logic                  out_valid,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_READ,
    S_CALC,
    S_WRITE
  } state_t;

  state_t state, state_nxt;

  logic                    dv_q;
  logic                    strobe;
  logic [AW-1:0]           clr_addr;
  logic [AW-1:0]           rd_ptr;
  logic [AW-1:0]           wr_ptr;
  logic [DW-1:0]           x_r;
  logic [AW-DELAY_LSB-1:0] dsel_r;
  logic                    mode_r;
  logic                    byp_r;
  logic [DW-1:0]           y_r;
  logic [DW-1:0]           y_calc;
  logic signed [DW-1:0]    echo;

  logic [DW-1:0]           mem [2**AW];
  logic [DW-1:0]           q;
  logic                    ram_we;
  logic                    ram_re;
  logic [AW-1:0]           ram_addr;
  logic [DW-1:0]           ram_wdata;

  assign strobe = data_valid & ~dv_q;
  assign busy   = (state == S_CLEAR);
  assign wr_ptr = rd_ptr + (AW'(dsel_r) << DELAY_LSB);
  assign echo   = $signed(q) >>> GAIN_SHIFT;

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state <= S_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = rd_ptr;
    ram_wdata = '0;
    case (state)
      S_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_addr;
        if (clr_addr == '1) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (strobe) begin
          ram_re    = 1'b1;
          state_nxt = S_READ;
        end
      end
      S_READ:  state_nxt = S_CALC;
      S_CALC:  state_nxt = S_WRITE;
      S_WRITE: begin
        ram_we    = 1'b1;
        ram_addr  = wr_ptr;
        ram_wdata = mode_r ? x_r : y_r;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  // Single-port RAM; the read port only updates when a sample is accepted.
  always_ff @(posedge sysclk) begin
    if (ram_re) q <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

`ifdef ECHO_SAT_EN
  localparam logic [DW-1:0] Y_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] Y_MIN = ~Y_MAX;
  logic [DW:0] y_wide;

  assign y_wide = {x_r[DW-1], x_r} - {echo[DW-1], echo};
`endif

  always_comb begin
    y_calc = x_r;
    if (!byp_r) begin
`ifdef ECHO_SAT_EN
      if (y_wide[DW] != y_wide[DW-1]) begin
        y_calc = y_wide[DW] ? Y_MIN : Y_MAX;
      end else begin
        y_calc = y_wide[DW-1:0];
      end
`else
      y_calc = x_r - echo;
`endif
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      dv_q      <= 1'b0;
      data_out  <= '0;
      out_valid <= 1'b0;
      rd_ptr    <= '0;
      clr_addr  <= '0;
      x_r       <= '0;
      dsel_r    <= '0;
      mode_r    <= 1'b0;
      byp_r     <= 1'b0;
      y_r       <= '0;
    end else begin
      dv_q      <= data_valid;
      out_valid <= 1'b0;
      case (state)
        S_CLEAR: clr_addr <= clr_addr + AW'(1);
        S_IDLE: begin
          if (strobe) begin
            x_r    <= data_in - ADC_OFFSET;
            dsel_r <= delay_sel;
            mode_r <= mode;
            byp_r  <= bypass;
          end
        end
        S_CALC:  y_r <= y_calc;
        S_WRITE: begin
          data_out  <= y_r + DAC_OFFSET;
          out_valid <= 1'b1;
          rd_ptr    <= rd_ptr + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_delay_line.sv
// Bench for echo_delay_line (DW=10, AW=4, DELAY_LSB=0, GAIN_SHIFT=1).
// Reference model: plain integer arithmetic over a 16-entry sample history.
module tb_echo_delay_line;

  localparam int DW    = 10;
  localparam int AW    = 4;
  localparam int DLSB  = 0;
  localparam int DEPTH = 16;

  logic                  sysclk;
  logic                  rst_n;
  logic [DW-1:0]         data_in;
  logic                  data_valid;
  logic [AW-DLSB-1:0]    delay_sel;
  logic                  mode;
  logic                  bypass;
  logic [DW-1:0]         data_out;
  logic                  out_valid;
  logic                  busy;

  int n_checks;
  int n_pass;

  int m_mem [DEPTH];
  int m_rd;

  echo_delay_line #(
    .DW         (DW),
    .AW         (AW),
    .ADC_OFFSET (10'h181),
    .DAC_OFFSET (10'h200),
    .GAIN_SHIFT (1),
    .DELAY_LSB  (DLSB)
  ) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .delay_sel  (delay_sel),
    .mode       (mode),
    .bypass     (bypass),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  function automatic int wrap_s(input int v);
    int r;
    r = v & 1023;
    if (r >= 512) r = r - 1024;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    m_rd = 0;
  endtask

  // Returns the expected data_out code for one accepted sample.
  function automatic int model_step(input int din, input int dsel, input bit m, input bit byp);
    int x, qv, ech, y;
    x   = wrap_s(din - 'h181);
    qv  = m_mem[m_rd];
    ech = qv >>> 1;
    if (byp) begin
      y = x;
    end else begin
      y = x - ech;
`ifdef ECHO_SAT_EN
      if (y > 511)  y = 511;
      if (y < -512) y = -512;
`else
      y = wrap_s(y);
`endif
    end
    m_mem[(m_rd + (dsel << DLSB)) % DEPTH] = m ? x : y;
    m_rd = (m_rd + 1) % DEPTH;
    return (y + 512) & 1023;
  endfunction

  // Called at a negedge; returns at a negedge with the DUT idle again.
  task automatic send(input string tag, input int din, input int dsel, input bit m,
                      input bit byp, output int got);
    int exp;
    bit early;
    exp        = model_step(din, dsel, m, byp);
    data_in    = din[DW-1:0];
    delay_sel  = dsel[AW-DLSB-1:0];
    mode       = m;
    bypass     = byp;
    data_valid = 1'b1;
    early      = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge sysclk);
      if (c == 0) data_valid = 1'b0;
      early |= (out_valid !== 1'b0);
    end
    n_checks++;
    if (early !== 1'b0) $display("FAIL %s early_out_valid: got 1 required 0 before cycle 4", tag);
    else n_pass++;
    @(negedge sysclk);
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL %s out_valid_latency: got %b required 1", tag, out_valid);
    else n_pass++;
    n_checks++;
    if (data_out !== exp[DW-1:0])
      $display("FAIL %s data_out: got %h required %h", tag, data_out, exp[DW-1:0]);
    else n_pass++;
    got = int'(data_out);
    @(negedge sysclk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL %s out_valid_pulse: got %b required 0", tag, out_valid);
    else n_pass++;
    @(negedge sysclk);
  endtask

  task automatic do_reset();
    int cnt;
    rst_n      = 1'b0;
    data_valid = 1'b0;
    repeat (2) @(negedge sysclk);
    rst_n = 1'b1;
    model_reset();
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge sysclk);
    end
    n_checks++;
    if (cnt !== 16) $display("FAIL reset_busy_len: got %0d required 16", cnt);
    else n_pass++;
  endtask

  task automatic test_reset();
    int cnt;
    bit seen;
    rst_n      = 1'b0;
    data_valid = 1'b0;
    repeat (2) @(negedge sysclk);
    n_checks++;
    if (data_out !== '0) $display("FAIL reset_data_out: got %h required 000", data_out);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL reset_busy: got %b required 1", busy);
    else n_pass++;
    rst_n = 1'b1;
    model_reset();
    cnt  = 0;
    seen = 1'b0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 4) data_valid = 1'b1;
      if (cnt == 8) data_valid = 1'b0;
      seen |= (out_valid !== 1'b0);
      @(negedge sysclk);
    end
    n_checks++;
    if (cnt !== 16) $display("FAIL clear_busy_len: got %0d required 16", cnt);
    else n_pass++;
    repeat (20) begin
      seen |= (out_valid !== 1'b0);
      @(negedge sysclk);
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL strobe_during_busy: got out_valid 1 required 0");
    else n_pass++;
  endtask

  task automatic test_ff_impulse();
    int got, lit;
    do_reset();
    for (int s = 0; s < 8; s++) begin
      send("ff_impulse", (s == 0) ? 'h1C1 : 'h181, 3, 1'b1, 1'b0, got);
      lit = (s == 0) ? 'h240 : (s == 3) ? 'h1E0 : 'h200;
      n_checks++;
      if (got !== lit) $display("FAIL ff_impulse_s%0d: got %h required %h", s, got, lit);
      else n_pass++;
    end
  endtask

  task automatic test_fb_impulse();
    int got, lit;
    do_reset();
    for (int s = 0; s < 10; s++) begin
      send("fb_impulse", (s == 0) ? 'h1C1 : 'h181, 3, 1'b0, 1'b0, got);
      lit = (s == 0) ? 'h240 : (s == 3) ? 'h1E0 : (s == 6) ? 'h210 : (s == 9) ? 'h1F8 : 'h200;
      n_checks++;
      if (got !== lit) $display("FAIL fb_impulse_s%0d: got %h required %h", s, got, lit);
      else n_pass++;
    end
  endtask

  task automatic test_max_delay();
    int got, lit;
    do_reset();
    for (int s = 0; s < 17; s++) begin
      send("max_delay", (s == 0) ? 'h1C1 : 'h181, 0, 1'b1, 1'b0, got);
      lit = (s == 0) ? 'h240 : (s == 16) ? 'h1E0 : 'h200;
      n_checks++;
      if (got !== lit) $display("FAIL max_delay_s%0d: got %h required %h", s, got, lit);
      else n_pass++;
    end
  endtask

  task automatic test_bypass();
    int got;
    do_reset();
    send("bypass", 'h1C1, 3, 1'b1, 1'b0, got);
    send("bypass", 'h181, 3, 1'b1, 1'b0, got);
    send("bypass", 'h181, 3, 1'b1, 1'b0, got);
    send("bypass", 'h300, 3, 1'b1, 1'b1, got);
    n_checks++;
    if (got !== 'h37F) $display("FAIL bypass_out: got %h required 37f", got);
    else n_pass++;
    send("bypass", 'h181, 3, 1'b1, 1'b0, got);
    send("bypass", 'h181, 3, 1'b1, 1'b0, got);
    send("bypass", 'h181, 3, 1'b1, 1'b0, got);
    n_checks++;
    if (got !== 'h141) $display("FAIL bypass_ram_write: got %h required 141", got);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int got, lit;
    do_reset();
    send("saturation", 'h380, 1, 1'b1, 1'b0, got);
    send("saturation", 'h000, 1, 1'b1, 1'b0, got);
`ifdef ECHO_SAT_EN
    lit = 'h000;
`else
    lit = 'h380;
`endif
    n_checks++;
    if (got !== lit) $display("FAIL saturation_s1: got %h required %h", got, lit);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int got, cnt;
    bit seen;
    do_reset();
    send("mid_reset", 'h300, 2, 1'b1, 1'b0, got);
    data_in    = 10'h2AA;
    data_valid = 1'b1;
    @(negedge sysclk);
    data_valid = 1'b0;
    @(negedge sysclk);
    rst_n = 1'b0;
    @(negedge sysclk);
    rst_n = 1'b1;
    model_reset();
    n_checks++;
    if (data_out !== '0) $display("FAIL mid_reset_data_out: got %h required 000", data_out);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL mid_reset_busy: got %b required 1", busy);
    else n_pass++;
    cnt  = 0;
    seen = 1'b0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      seen |= (out_valid !== 1'b0);
      @(negedge sysclk);
    end
    n_checks++;
    if (cnt !== 16) $display("FAIL mid_reset_clear_len: got %0d required 16", cnt);
    else n_pass++;
    n_checks++;
    if (seen !== 1'b0) $display("FAIL mid_reset_abandon: got out_valid 1 required 0");
    else n_pass++;
    send("mid_reset_after", 'h1C1, 5, 1'b0, 1'b0, got);
  endtask

  task automatic test_random();
    int got;
    do_reset();
    for (int s = 0; s < 60; s++) begin
      send("random", int'($urandom_range(1023, 0)), int'($urandom_range(DEPTH - 1, 0)),
           1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0), got);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    data_in    = '0;
    data_valid = 1'b0;
    delay_sel  = '0;
    mode       = 1'b0;
    bypass     = 1'b0;
    model_reset();
    @(negedge sysclk);
    test_reset();
    test_ff_impulse();
    test_fb_impulse();
    test_max_delay();
    test_bypass();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
